instr_mem_sync: RTL and testbench
=================================

Name: instr_mem_sync

Overview:
- Parametrised, clocked successor to the combinational instruction memory.
- Array is writable through a boot-load port. Instruction fetches use a valid/ready request/response handshake with 1-cycle read latency.
- Misaligned and out-of-range fetches are flagged, and an error counter is kept.
- Sits between the fetch stage (requester) and the boot loader (writer) of the MIPS core.

Parameters:
- DATA_WIDTH, 32, instruction word width
- ADDR_WIDTH, 32, byte-address width of fetch requests
- DEPTH_LOG2, 8, log2 of number of words (256 words); requires ADDR_WIDTH >= DEPTH_LOG2+2
- NOP_WORD, 32'h00000000, instruction returned on error
- ERR_CNT_WIDTH, 8, width of saturating error counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- load_en  in  1  boot-load write strobe
- load_addr  in  DEPTH_LOG2  word index for boot write
- load_data  in  DATA_WIDTH  word to write
- boot_done  in  1  pulse: loading finished, enter RUN
- running  out  1  1 when state is RUN
- req_valid  in  1  fetch request valid
- req_ready  out  1  fetch request accepted this cycle when req_valid && req_ready
- req_addr  in  ADDR_WIDTH  byte address of fetch
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer accepts response
- rsp_instr  out  DATA_WIDTH  fetched instruction
- rsp_err  out  1  response is an error (misaligned or out of range)
- err_count  out  ERR_CNT_WIDTH  saturating count of error responses accepted by the consumer

Behaviour:
- States: BOOT, RUN. Reset -> BOOT.
  - BOOT -> RUN on boot_done.
  - RUN -> BOOT only via rst.
  - boot_done in RUN is ignored.
- Reset values: running=0, rsp_valid=0, rsp_instr=NOP_WORD, rsp_err=0, err_count=0.
- rst does not clear the memory array; contents persist across reset. Array power-up contents are undefined.
- Boot load:
  - In BOOT, load_en=1 writes load_data to mem[load_addr] at the edge.
  - load_en in RUN is ignored; the array is unchanged.
  - load_en together with boot_done in the same cycle: the write is performed and the state becomes RUN.
- req_ready = running && (!rsp_valid || rsp_ready). This is combinational from the state and the output register only, never from req_valid.
- Accept (req_valid && req_ready) at edge N gives rsp_valid=1 with data after edge N, i.e. 1-cycle latency.
  - Back-to-back accepts are allowed when rsp_ready=1: one response per cycle.
- Response hold: while rsp_valid && !rsp_ready, rsp_instr and rsp_err are held stable and no new request is accepted.
- rsp_valid falls after an edge with rsp_ready=1 and no new accept.
- Address decode:
  - word index = req_addr[DEPTH_LOG2+1:2].
  - misaligned if req_addr[1:0] != 0.
  - out of range if any bit req_addr[ADDR_WIDTH-1:DEPTH_LOG2+2] is 1.
  - Either condition: rsp_err=1 and rsp_instr=NOP_WORD. Otherwise rsp_err=0 and rsp_instr=mem[index].
- Read-during-write cannot occur: loads only happen in BOOT and fetches only in RUN.
- err_count:
  - Increments by 1 on each edge where rsp_valid && rsp_ready && rsp_err.
  - Saturates at all-ones and never wraps.
  - Cleared only by rst.
- Reset mid-operation: a pending response is dropped (rsp_valid=0 after the edge), the state returns to BOOT, and err_count is cleared.
- A rsp_ready=1 coinciding with rst does not increment err_count.

Decomposition:
- Shared package (e.g. mips_pkg): state encoding constants (ST_BOOT, ST_RUN), NOP word constant, and a helper function for the address-error check.
- One natural sub-module: sync_ram_1w1r, a single-clock array with one write port and one registered read port.
  - Parameters: DATA_WIDTH, DEPTH_LOG2.
  - No reset on the array.
- The top level holds the FSM, handshake, error logic and counter.

Test Plan:
- Boot and fetch: reset; load mem[0]=32'h0003FFFF and mem[1]=32'h20080005; pulse boot_done; fetch addr 0 then 4 with rsp_ready=1 -> responses 32'h0003FFFF then 32'h20080005 on consecutive cycles, rsp_err=0, running=1.
- Gating: while in BOOT, req_valid=1 -> req_ready=0 and no response. In RUN, a load_en write to index 0 with 32'hDEADBEEF is ignored; a later fetch of addr 0 still returns 32'h0003FFFF.
- Backpressure: fetch addr 4 with rsp_ready=0 for 3 cycles -> rsp_valid stays 1, rsp_instr stays 32'h20080005, req_ready=0. When rsp_ready rises, the next request is accepted in the same cycle.
- Errors:
  - Fetch addr 32'h2 -> rsp_err=1, rsp_instr=NOP_WORD.
  - Fetch addr 32'h400 (index 256, out of range at DEPTH_LOG2=8) -> rsp_err=1.
  - err_count=2 after both are consumed.
- Saturation: with ERR_CNT_WIDTH=2, consume 5 error responses -> err_count=3.
- Reset mid-operation: assert rst while rsp_valid=1 and rsp_ready=1 -> rsp_valid=0, err_count=0, running=0. After boot_done, a fetch of addr 0 still returns 32'h0003FFFF because contents are retained.

Source files
------------

// File: rtl/instr_mem_sync_pkg.sv
// Shared definitions for the synchronous instruction memory: FSM state
// encoding, the default error instruction, and the fetch address check.
package instr_mem_sync_pkg;

  localparam logic [0:0] ST_BOOT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;

  // A fetch is in error when it is not word aligned or when any address
  // bit above the array's word index range is set. The address is passed
  // zero-extended to 64 bits so one function serves every ADDR_WIDTH.
  function automatic logic addr_err(input logic [63:0] addr,
                                    input int          addr_width,
                                    input int          depth_log2);
    logic err_s;
    err_s = (addr[1:0] != 2'b00);
    for (int i = 2; i < 64; i++) begin
      err_s = err_s | ((i >= depth_log2 + 2) && (i < addr_width) && addr[i]);
    end
    return err_s;
  endfunction

endpackage

// File: rtl/instr_mem_sync_ram.sv
// Single-clock storage array with one write port and one registered read
// port. The array has no reset so its contents survive a core reset.
module sync_ram_1w1r #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_r [(1 << DEPTH_LOG2)];
  logic [DATA_WIDTH-1:0] rdata_r;

  // Write port: store the word at the addressed location.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read port: capture the addressed word; holds when no read is issued.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/instr_mem_sync.sv
// Clocked instruction memory: boot-loaded array, valid/ready fetch port
// with one-cycle latency, error flagging and a saturating error counter.
module instr_mem_sync
  import instr_mem_sync_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    ADDR_WIDTH    = 32,
  parameter int                    DEPTH_LOG2    = 8,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD      = DATA_WIDTH'(NOP_WORD_DEF),
  parameter int                    ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_en,
  input  logic [DEPTH_LOG2-1:0]    load_addr,
  input  logic [DATA_WIDTH-1:0]    load_data,
  input  logic                     boot_done,
  output logic                     running,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_WIDTH-1:0]    req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_instr,
  output logic                     rsp_err,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX = {ERR_CNT_WIDTH{1'b1}};

  logic [0:0]               state_r;
  logic                     rsp_valid_r;
  logic                     rsp_err_r;
  logic                     rsp_nop_r;
  logic [ERR_CNT_WIDTH-1:0] err_count_r;
  logic [DATA_WIDTH-1:0]    ram_rdata_s;
  logic                     accept_s;
  logic                     addr_err_s;
  logic                     we_s;
  logic                     consume_err_s;

  assign running       = (state_r == ST_RUN);
  assign req_ready     = running && (!rsp_valid_r || rsp_ready);
  assign accept_s      = req_valid && req_ready;
  assign addr_err_s    = addr_err(64'(req_addr), ADDR_WIDTH, DEPTH_LOG2);
  assign we_s          = load_en && (state_r == ST_BOOT);
  assign consume_err_s = rsp_valid_r && rsp_ready && rsp_err_r;

  sync_ram_1w1r #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .we    (we_s),
    .waddr (load_addr),
    .wdata (load_data),
    .re    (accept_s),
    .raddr (req_addr[DEPTH_LOG2+1:2]),
    .rdata (ram_rdata_s)
  );

  // Boot/run FSM: leaves BOOT on boot_done, returns only through reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_BOOT;
    end else begin
      case (state_r)
        ST_BOOT: state_r <= boot_done ? ST_RUN : ST_BOOT;
        ST_RUN:  state_r <= ST_RUN;
        default: state_r <= ST_BOOT;
      endcase
    end
  end

  // Response register: loads on accept, holds under backpressure, clears
  // once consumed with no new request behind it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_nop_r   <= 1'b1;
    end else if (accept_s) begin
      rsp_valid_r <= 1'b1;
      rsp_err_r   <= addr_err_s;
      rsp_nop_r   <= addr_err_s;
    end else if (rsp_ready) begin
      rsp_valid_r <= 1'b0;
    end
  end

  // Error counter: counts error responses taken by the consumer, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count_r <= {ERR_CNT_WIDTH{1'b0}};
    end else if (consume_err_s && (err_count_r != ERR_MAX)) begin
      err_count_r <= err_count_r + {{(ERR_CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // The array read port already holds its word during backpressure; the
  // NOP flag substitutes the error/reset word in front of it.
  assign rsp_instr = rsp_nop_r ? NOP_WORD : ram_rdata_s;
  assign rsp_valid = rsp_valid_r;
  assign rsp_err   = rsp_err_r;
  assign err_count = err_count_r;

endmodule

// File: tb/tb_instr_mem_sync.sv
// Directed self-checking bench for instr_mem_sync (ERR_CNT_WIDTH=2 so that
// counter saturation is reachable quickly).
module tb_instr_mem_sync;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int DL  = 8;
  localparam int ECW = 2;
  localparam logic [DW-1:0] NOP = 32'h0000_0000;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           load_en = 1'b0;
  logic [DL-1:0]  load_addr = '0;
  logic [DW-1:0]  load_data = '0;
  logic           boot_done = 1'b0;
  logic           running;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic [AW-1:0]  req_addr = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [DW-1:0]  rsp_instr;
  logic           rsp_err;
  logic [ECW-1:0] err_count;

  int total = 0;
  int bad   = 0;

  instr_mem_sync #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .DEPTH_LOG2    (DL),
    .NOP_WORD      (NOP),
    .ERR_CNT_WIDTH (ECW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .boot_done (boot_done),
    .running   (running),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_instr (rsp_instr),
    .rsp_err   (rsp_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are then stable for checks.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++; if (running !== 1'b0) begin bad++; $display("FAIL reset_running got=%b exp=0", running); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    total++; if (rsp_instr !== NOP) begin bad++; $display("FAIL reset_rsp_instr got=%h exp=%h", rsp_instr, NOP); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
    total++; if (err_count !== 2'd0) begin bad++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
  endtask

  task automatic test_gating_boot();
    req_valid = 1'b1;
    req_addr  = 32'h0;
    rsp_ready = 1'b1;
    #1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL boot_req_ready got=%b exp=0", req_ready); end
    tick();
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL boot_no_rsp got=%b exp=0", rsp_valid); end
    req_valid = 1'b0;
  endtask

  task automatic test_boot_fetch();
    load_en = 1'b1; load_addr = 8'd0; load_data = 32'h0003FFFF;
    tick();
    load_addr = 8'd1; load_data = 32'h20080005;
    tick();
    load_en = 1'b0;
    boot_done = 1'b1;
    tick();
    boot_done = 1'b0;
    total++; if (running !== 1'b1) begin bad++; $display("FAIL boot_running got=%b exp=1", running); end
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h0;
    tick();
    total++; if (rsp_valid !== 1'b1 || rsp_instr !== 32'h0003FFFF || rsp_err !== 1'b0) begin
      bad++; $display("FAIL fetch0 got v=%b i=%h e=%b exp v=1 i=0003ffff e=0", rsp_valid, rsp_instr, rsp_err); end
    req_addr = 32'h4;
    tick();
    total++; if (rsp_valid !== 1'b1 || rsp_instr !== 32'h20080005 || rsp_err !== 1'b0) begin
      bad++; $display("FAIL fetch4 got v=%b i=%h e=%b exp v=1 i=20080005 e=0", rsp_valid, rsp_instr, rsp_err); end
    req_valid = 1'b0;
    tick();
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL fetch_drain got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_gating_run();
    load_en = 1'b1; load_addr = 8'd0; load_data = 32'hDEADBEEF;
    boot_done = 1'b1;
    tick();
    load_en = 1'b0;
    boot_done = 1'b0;
    total++; if (running !== 1'b1) begin bad++; $display("FAIL run_stays got=%b exp=1", running); end
    req_valid = 1'b1;
    req_addr  = 32'h0;
    tick();
    req_valid = 1'b0;
    total++; if (rsp_instr !== 32'h0003FFFF) begin bad++; $display("FAIL run_load_ignored got=%h exp=0003ffff", rsp_instr); end
    tick();
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_addr  = 32'h4;
    tick();
    req_addr = 32'h0;
    for (int k = 0; k < 3; k++) begin
      total++; if (rsp_valid !== 1'b1 || rsp_instr !== 32'h20080005 || req_ready !== 1'b0) begin
        bad++; $display("FAIL hold%0d got v=%b i=%h rdy=%b exp v=1 i=20080005 rdy=0", k, rsp_valid, rsp_instr, req_ready); end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL release_ready got=%b exp=1", req_ready); end
    tick();
    req_valid = 1'b0;
    total++; if (rsp_valid !== 1'b1 || rsp_instr !== 32'h0003FFFF) begin
      bad++; $display("FAIL release_next got v=%b i=%h exp v=1 i=0003ffff", rsp_valid, rsp_instr); end
    tick();
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL release_drain got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_errors();
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h2;
    tick();
    total++; if (rsp_err !== 1'b1 || rsp_instr !== NOP) begin
      bad++; $display("FAIL misaligned got e=%b i=%h exp e=1 i=%h", rsp_err, rsp_instr, NOP); end
    req_addr = 32'h400;
    tick();
    req_valid = 1'b0;
    total++; if (rsp_err !== 1'b1 || rsp_instr !== NOP) begin
      bad++; $display("FAIL out_of_range got e=%b i=%h exp e=1 i=%h", rsp_err, rsp_instr, NOP); end
    total++; if (err_count !== 2'd1) begin bad++; $display("FAIL err_count_mid got=%0d exp=1", err_count); end
    tick();
    total++; if (err_count !== 2'd2) begin bad++; $display("FAIL err_count_two got=%0d exp=2", err_count); end
  endtask

  task automatic test_saturation();
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h8000_0000;
    for (int k = 0; k < 5; k++) tick();
    req_valid = 1'b0;
    tick();
    total++; if (err_count !== 2'd3) begin bad++; $display("FAIL saturate got=%0d exp=3", err_count); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL saturate_drain got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h1;
    tick();
    req_valid = 1'b0;
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL mid_pending got=%b exp=1", rsp_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (rsp_valid !== 1'b0 || err_count !== 2'd0 || running !== 1'b0) begin
      bad++; $display("FAIL mid_reset got v=%b cnt=%0d run=%b exp v=0 cnt=0 run=0", rsp_valid, err_count, running); end
    boot_done = 1'b1;
    tick();
    boot_done = 1'b0;
    req_valid = 1'b1;
    req_addr  = 32'h0;
    tick();
    req_valid = 1'b0;
    total++; if (rsp_valid !== 1'b1 || rsp_instr !== 32'h0003FFFF || rsp_err !== 1'b0) begin
      bad++; $display("FAIL retained got v=%b i=%h e=%b exp v=1 i=0003ffff e=0", rsp_valid, rsp_instr, rsp_err); end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    #2;
    test_reset();
    test_gating_boot();
    test_boot_fetch();
    test_gating_run();
    test_backpressure();
    test_errors();
    test_saturation();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
